// File: rtl/bcd_countdown_timer_if.sv
// ---------------------------------------------------------------------------
// bcd_countdown_timer_if
//   Control / status bundle for the BCD countdown timer.
//   master : drives tick, load, load_value, start, stop;
//            observes count, running, done, load_err
//   slave  : the timer itself (opposite directions)
//   DIGITS : number of BCD digits; bus width is 4*DIGITS, digit 0 in [3:0]
// ---------------------------------------------------------------------------
interface bcd_countdown_timer_if #(
    parameter int DIGITS = 2
);
    logic                  tick;
    logic                  load;
    logic [4*DIGITS-1:0]   load_value;
    logic                  start;
    logic                  stop;
    logic [4*DIGITS-1:0]   count;
    logic                  running;
    logic                  done;
    logic                  load_err;

    modport master (
        output tick, load, load_value, start, stop,
        input  count, running, done, load_err
    );

    modport slave (
        input  tick, load, load_value, start, stop,
        output count, running, done, load_err
    );
endinterface

// File: rtl/bcd_countdown_timer.sv
// ---------------------------------------------------------------------------
// bcd_countdown_timer
//   Loadable multi-digit BCD down-counter. Each digit counts 9..0 and borrows
//   from the digit above; counting happens in RUN on cycles where tick=1.
//   Reaching zero emits a one-cycle done pulse and parks the counter in DONE.
//
// Ports:
//   clock  : system clock, rising edge
//   clear  : synchronous active-high reset (highest priority)
//   bus    : bcd_countdown_timer_if.slave
//              tick, load, load_value, start, stop  (inputs)
//              count, running, done, load_err       (registered outputs)
//
// Parameters:
//   DIGITS : number of BCD digits, 1..8
//
// Build option:
//   BCD_COUNTDOWN_AUTO_RELOAD_EN : when defined, reaching zero reloads the
//   last accepted preset and keeps running (done still pulses). A zero
//   preset falls back to entering DONE.
//
// Edge priority: clear > load > stop > start > tick.
// ---------------------------------------------------------------------------

// One BCD digit: decrement-with-borrow and preset validity check.
module bcd_countdown_digit (
    input  logic [3:0] cur,
    input  logic       borrow_in,
    input  logic [3:0] preset,
    output logic [3:0] nxt,
    output logic       borrow_out,
    output logic       preset_ok
);
    always_comb begin
        nxt        = cur;
        borrow_out = 1'b0;
        if (borrow_in) begin
            if (cur == 4'd0) begin
                nxt        = 4'd9;
                borrow_out = 1'b1;
            end else begin
                nxt = 4'(cur - 4'd1);
            end
        end
    end

    assign preset_ok = (preset <= 4'd9);
endmodule

module bcd_countdown_timer #(
    parameter int DIGITS = 2
) (
    input  logic                   clock,
    input  logic                   clear,
    bcd_countdown_timer_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE,
        S_DONE
    } state_t;

    state_t                   state, state_n;
    logic [DIGITS-1:0][3:0]   count_q, count_n;
    logic [DIGITS-1:0][3:0]   dec_val;
    logic [DIGITS-1:0][3:0]   preset;
    logic [DIGITS:0]          borrow;
    logic [DIGITS-1:0]        nib_ok;
    logic                     preset_ok;
    logic                     count_zero, dec_zero;
    logic                     running_q, running_n;
    logic                     done_q, done_n;
    logic                     load_err_q, load_err_n;

`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
    logic [DIGITS-1:0][3:0]   reload_q, reload_n;
`endif

    assign preset    = bus.load_value;
    assign borrow[0] = 1'b1;   // every decrement starts at digit 0

    // Borrow ripples upward through the digit array.
    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_countdown_digit u_digit (
            .cur        (count_q[g]),
            .borrow_in  (borrow[g]),
            .preset     (preset[g]),
            .nxt        (dec_val[g]),
            .borrow_out (borrow[g+1]),
            .preset_ok  (nib_ok[g])
        );
    end

    assign preset_ok  = &nib_ok;
    assign count_zero = (count_q == '0);
    assign dec_zero   = (dec_val == '0);

    // State, count and pulse registers.
    always_ff @(posedge clock) begin
        if (clear) begin
            state      <= S_IDLE;
            count_q    <= '0;
            running_q  <= 1'b0;
            done_q     <= 1'b0;
            load_err_q <= 1'b0;
`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
            reload_q   <= '0;
`endif
        end else begin
            state      <= state_n;
            count_q    <= count_n;
            running_q  <= running_n;
            done_q     <= done_n;
            load_err_q <= load_err_n;
`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
            reload_q   <= reload_n;
`endif
        end
    end

    // Next-state / next-output logic, evaluated in edge-priority order.
    always_comb begin
        state_n    = state;
        count_n    = count_q;
        done_n     = 1'b0;
        load_err_n = 1'b0;
`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
        reload_n   = reload_q;
`endif
        if (bus.load) begin
            // A preset with any non-BCD nibble is rejected wholesale so
            // count can never hold an illegal digit.
            if (preset_ok) begin
                count_n = preset;
                state_n = S_IDLE;
`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
                reload_n = preset;
`endif
            end else begin
                load_err_n = 1'b1;
            end
        end else if (bus.stop) begin
            // stop shadows a simultaneous start, so PAUSE stays PAUSE.
            if (state == S_RUN)
                state_n = S_PAUSE;
        end else if (bus.start) begin
            if ((state == S_IDLE && !count_zero) || state == S_PAUSE)
                state_n = S_RUN;
        end else if (bus.tick && state == S_RUN) begin
            count_n = dec_val;
            if (dec_zero) begin
                done_n  = 1'b1;
`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
                if (reload_q != '0)
                    count_n = reload_q;
                else
                    state_n = S_DONE;
`else
                state_n = S_DONE;
`endif
            end
        end
        running_n = (state_n == S_RUN);
    end

    assign bus.count    = count_q;
    assign bus.running  = running_q;
    assign bus.done     = done_q;
    assign bus.load_err = load_err_q;
endmodule

// File: doc/bcd_countdown_timer.md
Name: bcd_countdown_timer

Overview:
- Loadable multi-digit BCD down-counter (countdown timer), the count-down counterpart of the team's 4-bit synchronous BCD up-counter.
- Each digit counts 9..0 and borrows from the next digit up. Counting is gated by a tick strobe and controlled by start/stop/load.
- It signals terminal count with a one-cycle done pulse.
- Sits beside the up-counter in timing/display paths; its count bus can drive the same BCD display logic.

Parameters:
- DIGITS, 2, number of BCD digits (1..8); count width = 4*DIGITS.

Ports:
- clock  input  1  system clock; all logic on rising edge
- clear  input  1  synchronous, active-high reset
- tick  input  1  count-enable strobe; one decrement per cycle where tick=1 in RUN
- load  input  1  load request, sampled on rising edge
- load_value  input  4*DIGITS  BCD preset; digit 0 = bits [3:0]
- start  input  1  start/resume request
- stop  input  1  pause request
- count  output  4*DIGITS  current BCD value, registered
- running  output  1  high while state = RUN
- done  output  1  one-cycle pulse on reaching zero
- load_err  output  1  one-cycle pulse when a load is rejected

Behaviour:
- Interface: one clock (clock); reset is synchronous and active-high (clear). No asynchronous reset anywhere.
- Reset values: count=0, state=IDLE, running=0, done=0, load_err=0, reload register=0.
- States:
  - IDLE: holds count.
  - RUN: decrements on tick.
  - PAUSE: holds count.
  - DONE: count=0, holds.
- Priority per edge: clear > load > stop > start > tick.
- load (any state):
  - If every nibble of load_value is <=9: count<=load_value, reload register<=load_value, state<=IDLE.
  - If any nibble is >9: count, state and reload register are unchanged; load_err=1 for that single cycle.
- start:
  - IDLE with count!=0 -> RUN.
  - IDLE with count==0 -> ignored; no done pulse.
  - PAUSE -> RUN.
  - Ignored in RUN and DONE.
- stop:
  - RUN -> PAUSE.
  - Ignored elsewhere.
  - stop and start asserted in the same cycle: stop wins (RUN->PAUSE; PAUSE stays PAUSE).
- Decrement (RUN and tick=1, no higher-priority event):
  - Digit 0 decrements.
  - A digit at 0 becomes 9 and borrows into the next digit.
  - The new value appears on count at the same edge (1-cycle latency from tick sample).
- Terminal count:
  - When the decrement yields all-zero (e.g. 01->00), the same edge sets state<=DONE and done=1.
  - done is low the next cycle unless re-triggered.
  - running falls at that edge.
- tick outside RUN is ignored.
- Clear mid-count returns all reset values at the next edge, regardless of other inputs.
- Outputs are never non-BCD: count digits are always 0..9.
- running and done are registered, aligned with count.

Optional Feature:
- Macro: BCD_COUNTDOWN_AUTO_RELOAD_EN.
- Defined:
  - On reaching zero, done still pulses for one cycle.
  - At that same edge, count<=reload register and state stays RUN; running stays 1.
  - If the reload register is 0, behaviour falls back to entering DONE.
  - load, stop and clear rules are unchanged.
- Undefined: terminal count enters DONE as above; the reload register is unused and may be optimised away.

Test Plan:
- DIGITS=2; clear=1 for 2 cycles, then 0 -> count=00, running=0, done=0, load_err=0.
- load 8'h12, start, tick held 1 -> count 12,11,10,09,...,01,00 on successive edges. done=1 exactly on the edge count becomes 00; running=0 after; count stays 00 with further ticks.
- load 8'h30, start, 3 ticks -> 29,28,27. Then stop+start together -> PAUSE, count holds 27 over 5 ticks. Then start -> resumes 26.
- In IDLE with count=45: load 8'h4A -> load_err pulses 1 cycle, count stays 45. Then start with count=00 after clear -> stays IDLE, running=0, no done.
- During RUN at count=07, assert clear -> next edge count=00, IDLE, running=0. Also load 8'h99 during RUN -> count=99, state IDLE.
- With BCD_COUNTDOWN_AUTO_RELOAD_EN: load 8'h03, start, ticks -> 02,01,00->03 (done pulse on the wrap edge), 02,...; running stays 1. Without the macro, the same stimulus stops at 00.
